// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer: entry layout, pointer widths and walk states.
package reorder_buffer_pkg;

  localparam int ROB_SZ          = 32;
  localparam int ROB_IDX_W       = $clog2(ROB_SZ);
  localparam int PHYS_REG_IDX_SZ = 6;
  localparam int PR_W            = PHYS_REG_IDX_SZ + 1;
  localparam int ARCH_W          = 5;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [ROB_IDX_W:0]   rob_cnt_t;
  typedef logic [PR_W-1:0]      pr_t;
  typedef logic [ARCH_W-1:0]    arch_t;

  typedef struct packed {
    logic  valid;
    logic  complete;
    logic  mispred;
    logic  has_dest;
    arch_t arch;
    pr_t   new_pr;
    pr_t   old_pr;
  } rob_entry_t;

  typedef logic [0:0] rob_state_t;
  localparam rob_state_t NORMAL = 1'b0;
  localparam rob_state_t WALK   = 1'b1;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / completion / retirement / free-list bundle between the pipeline and the reorder buffer.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic     dispatch_en;
  logic     dispatch_has_dest;
  arch_t    dispatch_arch;
  pr_t      dispatch_pr;
  pr_t      dispatch_old_pr;
  logic     dispatch_ok;
  rob_idx_t dispatch_idx;

  logic     complete_en;
  rob_idx_t complete_idx;
  logic     complete_mispred;

  logic     retire_valid;
  arch_t    retire_arch;
  pr_t      retire_pr;

  logic     free_en;
  pr_t      free_pr;

  logic     recovering;
  logic     flush_done;

  modport master (
    output dispatch_en, dispatch_has_dest, dispatch_arch, dispatch_pr, dispatch_old_pr,
    output complete_en, complete_idx, complete_mispred,
    input  dispatch_ok, dispatch_idx, retire_valid, retire_arch, retire_pr,
    input  free_en, free_pr, recovering, flush_done
  );

  modport slave (
    input  dispatch_en, dispatch_has_dest, dispatch_arch, dispatch_pr, dispatch_old_pr,
    input  complete_en, complete_idx, complete_mispred,
    output dispatch_ok, dispatch_idx, retire_valid, retire_arch, retire_pr,
    output free_en, free_pr, recovering, flush_done
  );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: retires completed heads to the free list and, after a retiring
// mispredict, walks from the youngest entry back to the head returning squashed PRs one per cycle.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  reorder_buffer_if.slave  rob
);

  rob_entry_t entries_q [ROB_SZ];
  rob_entry_t entries_d [ROB_SZ];
  rob_idx_t   head_q, head_d;
  rob_idx_t   tail_q, tail_d;
  rob_idx_t   walk_ptr_q, walk_ptr_d;
  rob_cnt_t   count_q, count_d;
  rob_state_t state_q, state_d;
  logic       flush_pend_q, flush_pend_d;

  rob_entry_t head_e, walk_e;
  logic       is_normal, do_dispatch, do_retire;

  assign head_e      = entries_q[head_q];
  assign walk_e      = entries_q[walk_ptr_q];
  assign is_normal   = (state_q == NORMAL);
  assign do_dispatch = rob.dispatch_en && rob.dispatch_ok;
  assign do_retire   = is_normal && head_e.valid && head_e.complete;

  // Outputs depend on registered state only, so a same-cycle retire cannot open a slot.
  always_comb begin
    rob.dispatch_ok  = is_normal && (count_q < rob_cnt_t'(ROB_SZ));
    rob.dispatch_idx = tail_q;
    rob.retire_valid = do_retire;
    rob.retire_arch  = do_retire ? head_e.arch   : '0;
    rob.retire_pr    = do_retire ? head_e.new_pr : '0;
    rob.recovering   = !is_normal;
    rob.flush_done   = flush_pend_q;
    if (is_normal) begin
      rob.free_en = do_retire && head_e.has_dest;
      rob.free_pr = rob.free_en ? head_e.old_pr : '0;
    end else begin
      rob.free_en = walk_e.valid && walk_e.has_dest;
      rob.free_pr = rob.free_en ? walk_e.new_pr : '0;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    entries_d    = entries_q;
    head_d       = head_q;
    tail_d       = tail_q;
    walk_ptr_d   = walk_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    flush_pend_d = 1'b0;

    if (is_normal) begin
      if (rob.complete_en && entries_q[rob.complete_idx].valid) begin
        entries_d[rob.complete_idx].complete = 1'b1;
        entries_d[rob.complete_idx].mispred  = rob.complete_mispred;
      end

      if (do_dispatch) begin
        entries_d[tail_q] = '{valid:    1'b1,
                              complete: 1'b0,
                              mispred:  1'b0,
                              has_dest: rob.dispatch_has_dest,
                              arch:     rob.dispatch_arch,
                              new_pr:   rob.dispatch_pr,
                              old_pr:   rob.dispatch_old_pr};
        tail_d = tail_q + rob_idx_t'(1);
      end

      if (do_retire) begin
        entries_d[head_q].valid = 1'b0;
        head_d                  = head_q + rob_idx_t'(1);
      end

      case ({do_dispatch, do_retire})
        2'b10:   count_d = count_q + rob_cnt_t'(1);
        2'b01:   count_d = count_q - rob_cnt_t'(1);
        default: count_d = count_q;
      endcase

      // A retiring mispredict squashes everything younger, including a same-cycle dispatch.
      if (do_retire && head_e.mispred) begin
        if (count_d != '0) begin
          state_d    = WALK;
          walk_ptr_d = tail_d - rob_idx_t'(1);
        end else begin
          flush_pend_d = 1'b1;
        end
      end
    end else begin
      entries_d[walk_ptr_q].valid = 1'b0;
      if (walk_ptr_q == head_q) begin
        state_d      = NORMAL;
        tail_d       = head_q;
        count_d      = '0;
        flush_pend_d = 1'b1;
      end else begin
        walk_ptr_d = walk_ptr_q - rob_idx_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      walk_ptr_q   <= '0;
      count_q      <= '0;
      state_q      <= NORMAL;
      flush_pend_q <= 1'b0;
      // NOTE: only the status bits of the entry array are reset; payload is qualified by valid.
      for (int i = 0; i < ROB_SZ; i++) begin
        entries_q[i].valid    <= 1'b0;
        entries_q[i].complete <= 1'b0;
        entries_q[i].mispred  <= 1'b0;
      end
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      walk_ptr_q   <= walk_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      entries_q    <= entries_d;
    end
  end

endmodule
